// File: rtl/wb_slave_ctrl.sv
// Wishbone classic slave sitting between the bus master and the SD host core.
// Decodes register / FIFO / command-execute / data-execute accesses, stretches
// execute accesses until the host core reports completion, and terminates
// with err_o when the host core never answers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for cyc_i & stb_i, latches address/direction/data
// S_WR      | register or FIFO write strobe and ack are on the bus
// S_RD_REQ  | read strobe is on the bus to the host core
// S_RD_WAIT | waiting out the host read latency, then captures data
// S_EXEC    | command/data request held until done, timeout or abort
// S_DONE    | ack (or err) cycle of a read or execute access

module wb_slave_ctrl #(
   parameter int DATA_W      = 64,
   parameter int ADR_W       = 5,
   parameter int CMD_ADR     = 18,
   parameter int FIFO_WR_ADR = 19,
   parameter int FIFO_RD_ADR = 20,
   parameter int DATA_ADR    = 21,
   parameter int READ_LAT    = 1,
   parameter int TIMEOUT_W   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [ADR_W-1:0]  adr_i,
   input  logic [DATA_W-1:0] dat_i,
   output logic [DATA_W-1:0] dat_o,
   output logic              ack_o,
   output logic              err_o,
   input  logic [DATA_W-1:0] host_data_i,
   input  logic              cmd_done_i,
   input  logic              data_done_i,
   output logic [DATA_W-1:0] host_data_o,
   output logic [ADR_W-1:0]  reg_adr_o,
   output logic              reg_write_en,
   output logic              reg_read_en,
   output logic              fifo_write_en,
   output logic              fifo_read_en,
   output logic              new_command,
   output logic              new_data
);

   localparam logic [ADR_W-1:0]     L_CMD      = ADR_W'(CMD_ADR);
   localparam logic [ADR_W-1:0]     L_FIFO_WR  = ADR_W'(FIFO_WR_ADR);
   localparam logic [ADR_W-1:0]     L_FIFO_RD  = ADR_W'(FIFO_RD_ADR);
   localparam logic [ADR_W-1:0]     L_DATA     = ADR_W'(DATA_ADR);
   localparam logic [1:0]           L_LAT_LD   = 2'(READ_LAT - 1);
   // The terminal compare fires one cycle before the count would reach
   // all-ones, so the request stays up for exactly 2^TIMEOUT_W-1 cycles.
   localparam logic [TIMEOUT_W-1:0] L_TMO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_EXEC, S_DONE
   } state_t;

   state_t              r_state;
   logic [ADR_W-1:0]    r_adr;
   logic                r_we;
   logic [DATA_W-1:0]   r_host_data;
   logic [DATA_W-1:0]   r_dat;
   logic                r_ack;
   logic                r_err;
   logic                r_reg_we;
   logic                r_reg_re;
   logic                r_fifo_we;
   logic                r_fifo_re;
   logic                r_new_cmd;
   logic                r_new_data;
   logic [1:0]          r_lat;
   logic [TIMEOUT_W-1:0] r_tmo;

   logic w_abort;
   logic w_done;
   logic w_first;

   // Master withdrawal, done source select and stale-done mask.
   assign w_abort = ~(cyc_i & stb_i);
   assign w_done  = r_new_cmd ? cmd_done_i : data_done_i;
   assign w_first = (r_tmo == '0);

   // Single registered FSM; strobes and terminations default low so they pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_adr       <= '0;
         r_we        <= 1'b0;
         r_host_data <= '0;
         r_dat       <= '0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
         r_reg_we    <= 1'b0;
         r_reg_re    <= 1'b0;
         r_fifo_we   <= 1'b0;
         r_fifo_re   <= 1'b0;
         r_new_cmd   <= 1'b0;
         r_new_data  <= 1'b0;
         r_lat       <= '0;
         r_tmo       <= '0;
      end else begin
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_reg_we  <= 1'b0;
         r_reg_re  <= 1'b0;
         r_fifo_we <= 1'b0;
         r_fifo_re <= 1'b0;
         r_dat     <= '0;
         case (r_state)
            S_IDLE: begin
               if (cyc_i && stb_i) begin
                  r_adr       <= adr_i;
                  r_we        <= we_i;
                  r_host_data <= dat_i;
                  if (we_i) begin
                     if (adr_i == L_CMD) begin
                        r_state   <= S_EXEC;
                        r_new_cmd <= 1'b1;
                        r_tmo     <= '0;
                     end else if (adr_i == L_DATA) begin
                        r_state     <= S_EXEC;
                        r_new_data  <= 1'b1;
                        r_host_data <= '0;
                        r_tmo       <= '0;
                     end else begin
                        r_state <= S_WR;
                        r_ack   <= 1'b1;
                        // Writes to the pop address are acked but dropped.
                        if (adr_i == L_FIFO_WR) r_fifo_we <= 1'b1;
                        else if (adr_i != L_FIFO_RD) r_reg_we <= 1'b1;
                     end
                  end else begin
                     r_state <= S_RD_REQ;
                     if (adr_i == L_FIFO_RD) r_fifo_re <= 1'b1;
                     else r_reg_re <= 1'b1;
                  end
               end
            end
            S_WR: begin
               r_state     <= S_IDLE;
               r_host_data <= '0;
            end
            S_RD_REQ: begin
               if (w_abort) begin
                  r_state     <= S_IDLE;
                  r_host_data <= '0;
               end else begin
                  r_state <= S_RD_WAIT;
                  r_lat   <= L_LAT_LD;
               end
            end
            S_RD_WAIT: begin
               if (w_abort) begin
                  r_state     <= S_IDLE;
                  r_host_data <= '0;
               end else if (r_lat == 2'd0 && !r_we) begin
                  r_state <= S_DONE;
                  r_dat   <= host_data_i;
                  r_ack   <= 1'b1;
               end else begin
                  r_lat <= r_lat - 2'd1;
               end
            end
            S_EXEC: begin
               if (w_abort) begin
                  r_state     <= S_IDLE;
                  r_new_cmd   <= 1'b0;
                  r_new_data  <= 1'b0;
                  r_host_data <= '0;
               end else if (!w_first && w_done) begin
                  r_state    <= S_DONE;
                  r_ack      <= 1'b1;
                  r_new_cmd  <= 1'b0;
                  r_new_data <= 1'b0;
               end else if (r_tmo == L_TMO_LAST) begin
                  r_state    <= S_DONE;
                  r_err      <= 1'b1;
                  r_new_cmd  <= 1'b0;
                  r_new_data <= 1'b0;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_host_data <= '0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dat_o         = r_dat;
   assign ack_o         = r_ack;
   assign err_o         = r_err;
   assign host_data_o   = r_host_data;
   assign reg_adr_o     = r_adr;
   assign reg_write_en  = r_reg_we;
   assign reg_read_en   = r_reg_re;
   assign fifo_write_en = r_fifo_we;
   assign fifo_read_en  = r_fifo_re;
   assign new_command   = r_new_cmd;
   assign new_data      = r_new_data;

endmodule

// File: tb/tb_wb_slave_ctrl.sv
// Bench for wb_slave_ctrl: each directed transaction writes its expected
// output timeline (per cycle) into arrays; a negedge process compares the DUT
// against that timeline every cycle, and literal checks pin key cycles.

module tb_wb_slave_ctrl;

   localparam int DW   = 64;
   localparam int AW   = 5;
   localparam int RL   = 1;
   localparam int TW   = 3;
   localparam int TM   = (1 << TW) - 1;
   localparam int MAXC = 400;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [AW-1:0] adr_i = '0;
   logic [DW-1:0] dat_i = '0;
   logic [DW-1:0] host_data_i = '0;
   logic          cmd_done_i = 1'b0, data_done_i = 1'b0;
   logic [DW-1:0] dat_o, host_data_o;
   logic          ack_o, err_o;
   logic [AW-1:0] reg_adr_o;
   logic          reg_write_en, reg_read_en, fifo_write_en, fifo_read_en;
   logic          new_command, new_data;

   wb_slave_ctrl #(
      .DATA_W(DW), .ADR_W(AW), .CMD_ADR(18), .FIFO_WR_ADR(19),
      .FIFO_RD_ADR(20), .DATA_ADR(21), .READ_LAT(RL), .TIMEOUT_W(TW)
   ) dut (
      .clock(clk), .reset(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
      .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
      .host_data_i(host_data_i), .cmd_done_i(cmd_done_i), .data_done_i(data_done_i),
      .host_data_o(host_data_o), .reg_adr_o(reg_adr_o),
      .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
      .fifo_write_en(fifo_write_en), .fifo_read_en(fifo_read_en),
      .new_command(new_command), .new_data(new_data)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // expected timeline
   bit          e_ack[MAXC], e_err[MAXC], e_rwe[MAXC], e_rre[MAXC];
   bit          e_fwe[MAXC], e_fre[MAXC], e_ncmd[MAXC], e_ndat[MAXC];
   bit [DW-1:0] e_dat[MAXC], e_hdo[MAXC];
   bit [AW-1:0] e_adr[MAXC];
   // observed history
   bit          h_ack[MAXC], h_err[MAXC], h_rwe[MAXC], h_fwe[MAXC];
   bit          h_fre[MAXC], h_ncmd[MAXC], h_ndat[MAXC];
   bit [DW-1:0] h_dat[MAXC], h_hdo[MAXC];

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   int cc;

   task automatic chk(input string nm, input int c, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d got %0h expected %0h", nm, c, got, exp);
   endtask

   // Per-cycle comparison of every output against the expected timeline.
   always @(negedge clk) begin
      if (chk_en && cyc_cnt < MAXC) begin
         cc = cyc_cnt;
         h_ack[cc] = ack_o;  h_err[cc] = err_o;  h_rwe[cc] = reg_write_en;
         h_fwe[cc] = fifo_write_en;  h_fre[cc] = fifo_read_en;
         h_ncmd[cc] = new_command;  h_ndat[cc] = new_data;
         h_dat[cc] = dat_o;  h_hdo[cc] = host_data_o;
         chk("ack_o", cc, DW'(ack_o), DW'(e_ack[cc]));
         chk("err_o", cc, DW'(err_o), DW'(e_err[cc]));
         chk("reg_write_en", cc, DW'(reg_write_en), DW'(e_rwe[cc]));
         chk("reg_read_en", cc, DW'(reg_read_en), DW'(e_rre[cc]));
         chk("fifo_write_en", cc, DW'(fifo_write_en), DW'(e_fwe[cc]));
         chk("fifo_read_en", cc, DW'(fifo_read_en), DW'(e_fre[cc]));
         chk("new_command", cc, DW'(new_command), DW'(e_ncmd[cc]));
         chk("new_data", cc, DW'(new_data), DW'(e_ndat[cc]));
         chk("dat_o", cc, dat_o, e_dat[cc]);
         chk("host_data_o", cc, host_data_o, e_hdo[cc]);
         chk("reg_adr_o", cc, DW'(reg_adr_o), DW'(e_adr[cc]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_adr(input int c, input logic [AW-1:0] a);
      for (int i = c; i < MAXC; i++) e_adr[i] = a;
   endtask

   task automatic drive(input logic s, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      cyc_i = s; stb_i = s; we_i = w; adr_i = a; dat_i = d;
   endtask

   // Plain write: ack plus the address-selected strobe one cycle after accept.
   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit keep, output int n);
      n = cyc_cnt;
      drive(1'b1, 1'b1, a, d);
      set_adr(n + 1, a);
      e_ack[n+1] = 1'b1;
      e_hdo[n+1] = d;
      if (a == 5'd19) e_fwe[n+1] = 1'b1;
      else if (a != 5'd20) e_rwe[n+1] = 1'b1;
      tick();
      if (!keep) drive(1'b0, 1'b0, a, d);
      tick();
   endtask

   // Read: strobe at N+1, data valid RL cycles after strobe, ack one later.
   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] val, input int abort_at, output int n);
      bit ab;
      n  = cyc_cnt;
      ab = (abort_at >= 1 && abort_at <= 1 + RL);
      drive(1'b1, 1'b0, a, d);
      set_adr(n + 1, a);
      if (a == 5'd20) e_fre[n+1] = 1'b1;
      else e_rre[n+1] = 1'b1;
      if (ab) begin
         for (int k = 1; k <= abort_at; k++) e_hdo[n+k] = d;
      end else begin
         for (int k = 1; k <= 2 + RL; k++) e_hdo[n+k] = d;
         e_ack[n+2+RL] = 1'b1;
         e_dat[n+2+RL] = val;
      end
      for (int k = 1; k <= 2 + RL; k++) begin
         tick();
         host_data_i = (k == 1 + RL) ? val : (64'hBAD0_0000_0000_0000 | DW'(k));
         if ((ab && k >= abort_at) || k == 2 + RL) drive(1'b0, 1'b0, a, d);
      end
      tick();
      host_data_i = '0;
   endtask

   // Execute access: request held from N+1 until done (k>=2), abort or timeout.
   task automatic ex(input logic [AW-1:0] a, input logic [DW-1:0] d, input int done_at,
                     input int stale_at, input int abort_at, output int n);
      bit is_cmd;
      int kind;  // 0 ack, 1 err, 2 abort
      int last;
      logic [DW-1:0] hd;
      n      = cyc_cnt;
      is_cmd = (a == 5'd18);
      hd     = is_cmd ? d : '0;
      if (abort_at > 0 && abort_at <= TM && (done_at < 2 || abort_at <= done_at)) begin
         kind = 2; last = abort_at;
      end else if (done_at >= 2 && done_at <= TM) begin
         kind = 0; last = done_at;
      end else begin
         kind = 1; last = TM;
      end
      drive(1'b1, 1'b1, a, d);
      set_adr(n + 1, a);
      for (int k = 1; k <= last; k++) begin
         if (is_cmd) e_ncmd[n+k] = 1'b1;
         else e_ndat[n+k] = 1'b1;
         e_hdo[n+k] = hd;
      end
      if (kind != 2) begin
         e_hdo[n+last+1] = hd;
         if (kind == 0) e_ack[n+last+1] = 1'b1;
         else e_err[n+last+1] = 1'b1;
      end
      for (int k = 1; k <= last + 1; k++) begin
         tick();
         cmd_done_i  = is_cmd && k <= last && (k == done_at || k == stale_at);
         data_done_i = !is_cmd && k <= last && (k == done_at || k == stale_at);
         if (k > last || (abort_at > 0 && k >= abort_at)) drive(1'b0, 1'b0, a, d);
      end
      tick();
      cmd_done_i  = 1'b0;
      data_done_i = 1'b0;
   endtask

   initial begin
      int n, n2, cnt;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ack", cyc_cnt, DW'(ack_o), DW'(0));
      chk("rst_host_data", cyc_cnt, host_data_o, DW'(0));
      chk("rst_new_command", cyc_cnt, DW'(new_command), DW'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // register write
      wr(5'd3, 64'hA5, 1'b0, n);
      chk("w3_rwe", n + 1, DW'(h_rwe[n+1]), DW'(1));
      chk("w3_hdo", n + 1, h_hdo[n+1], 64'hA5);
      chk("w3_ack", n + 1, DW'(h_ack[n+1]), DW'(1));
      chk("w3_ack_after", n + 2, DW'(h_ack[n+2]), DW'(0));
      tick();

      // FIFO pop read with host data valid only at N+2
      rd(5'd20, 64'h77, 64'h1234, 0, n);
      chk("r20_fre", n + 1, DW'(h_fre[n+1]), DW'(1));
      chk("r20_early_ack", n + 2, DW'(h_ack[n+2]), DW'(0));
      chk("r20_ack", n + 3, DW'(h_ack[n+3]), DW'(1));
      chk("r20_dat", n + 3, h_dat[n+3], 64'h1234);

      rd(5'd7, 64'h0, 64'hCAFE_F00D_0000_0001, 0, n);
      wr(5'd20, 64'h99, 1'b0, n);

      // command with a stale done in the first exec cycle
      ex(5'd18, 64'hDEAD, 5, 1, 0, n);
      chk("cmd_req_n5", n + 5, DW'(h_ncmd[n+5]), DW'(1));
      chk("cmd_req_n6", n + 6, DW'(h_ncmd[n+6]), DW'(0));
      chk("cmd_ack_n6", n + 6, DW'(h_ack[n+6]), DW'(1));
      chk("cmd_no_ack_n2", n + 2, DW'(h_ack[n+2]), DW'(0));

      // data timeout
      ex(5'd21, 64'h1111, 0, 0, 0, n);
      cnt = 0;
      for (int i = n; i <= n + 12; i++) cnt += int'(h_ndat[i]);
      chk("tmo_req_len", n, DW'(cnt), DW'(7));
      chk("tmo_err", n + 8, DW'(h_err[n+8]), DW'(1));
      chk("tmo_no_ack", n + 8, DW'(h_ack[n+8]), DW'(0));

      ex(5'd21, 64'h2222, 2, 0, 0, n);
      ex(5'd21, 64'h3333, 7, 0, 0, n);
      chk("done_on_last_ack", n + 8, DW'(h_ack[n+8]), DW'(1));

      // command abort
      ex(5'd18, 64'hBEEF, 0, 0, 3, n);
      chk("abort_req_n3", n + 3, DW'(h_ncmd[n+3]), DW'(1));
      chk("abort_req_n4", n + 4, DW'(h_ncmd[n+4]), DW'(0));
      chk("abort_no_term", n + 4, DW'(h_ack[n+4] | h_err[n+4]), DW'(0));

      rd(5'd9, 64'h55, 64'h4444, 2, n);

      // back-to-back writes
      wr(5'd19, 64'hF1F0, 1'b1, n);
      wr(5'd5, 64'h0505, 1'b0, n2);
      chk("b2b_fwe", n + 1, DW'(h_fwe[n+1]), DW'(1));
      chk("b2b_rwe", n + 3, DW'(h_rwe[n+3]), DW'(1));
      chk("b2b_ack1", n + 1, DW'(h_ack[n+1]), DW'(1));
      chk("b2b_ack2", n + 3, DW'(h_ack[n+3]), DW'(1));
      tick();

      // reset asserted mid-exec
      n = cyc_cnt;
      drive(1'b1, 1'b1, 5'd18, 64'h7777);
      set_adr(n + 1, 5'd18);
      e_ncmd[n+1] = 1'b1;
      e_hdo[n+1]  = 64'h7777;
      set_adr(n + 2, 5'd0);
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", cyc_cnt, DW'(new_command), DW'(0));
      chk("rst_mid_hdo", cyc_cnt, host_data_o, DW'(0));
      chk("rst_mid_adr", cyc_cnt, DW'(reg_adr_o), DW'(0));
      drive(1'b0, 1'b0, 5'd0, 64'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      wr(5'd4, 64'h4040, 1'b0, n);
      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_slave_ctrl.md
Name: wb_slave_ctrl

Overview:
- Parametrised Wishbone classic slave between the Wishbone master and the SD host core.
- Decodes register, FIFO, command-execute and data-execute accesses.
- Inserts wait states until the host core signals completion, with a timeout that terminates on err_o.
- Supports configurable data/address width, decode addresses and host read latency.
- Adds cyc_i qualification and abort on master withdrawal.

Parameters:
DATA_W, 64, width of Wishbone and host data buses
ADR_W, 5, width of adr_i and reg_adr_o
CMD_ADR, 18, write here launches a command (waits on cmd_done_i)
FIFO_WR_ADR, 19, write here pushes the host FIFO
FIFO_RD_ADR, 20, read here pops the host FIFO
DATA_ADR, 21, write here launches a data transfer (waits on data_done_i)
READ_LAT, 1, cycles from read-enable pulse to host_data_i valid (1..4)
TIMEOUT_W, 8, execute timeout = 2^TIMEOUT_W-1 cycles

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
cyc_i  in  1  Wishbone cycle
stb_i  in  1  Wishbone strobe
we_i  in  1  1=write, 0=read
adr_i  in  ADR_W  register address
dat_i  in  DATA_W  write data
dat_o  out  DATA_W  read data, valid only while ack_o=1, else 0
ack_o  out  1  one-cycle normal termination
err_o  out  1  one-cycle error termination (timeout)
host_data_i  in  DATA_W  read data from host core
cmd_done_i  in  1  command complete
data_done_i  in  1  data transfer complete
host_data_o  out  DATA_W  write data to host core, 0 when idle
reg_adr_o  out  ADR_W  latched access address
reg_write_en, reg_read_en, fifo_write_en, fifo_read_en  out  1 each  one-cycle strobes
new_command, new_data  out  1 each  level requests, held until done/timeout/abort

Behaviour:
- All outputs are registered.
- reset low clears every output, the state and the timeout counter to 0 immediately, including mid-transfer.
- States: IDLE, WR, RD_REQ, RD_WAIT, EXEC, DONE.
- IDLE:
  - Accepts a transfer when cyc_i&stb_i are sampled high (cycle N).
  - Latches adr_i, we_i and dat_i into reg_adr_o, the direction register and host_data_o.
- Write to FIFO_WR_ADR or any non-special address (WR state):
  - Cycle N+1: fifo_write_en or reg_write_en =1, host_data_o=dat_i, ack_o=1.
  - Cycle N+2: back in IDLE.
- Write to FIFO_RD_ADR: ack_o at N+1 with no strobe (ignored write).
- Read (RD_REQ, RD_WAIT):
  - Cycle N+1: fifo_read_en (adr=FIFO_RD_ADR) or reg_read_en (any other address) pulses.
  - host_data_i is captured READ_LAT cycles later.
  - Cycle N+2+READ_LAT: dat_o=captured value, ack_o=1.
- Write to CMD_ADR / DATA_ADR (EXEC state):
  - From N+1: new_command (or new_data) =1; host_data_o=dat_i for CMD, 0 for DATA.
  - The done input is ignored in the first EXEC cycle (N+1) to mask stale done; minimum EXEC length is 2 cycles.
  - Done sampled high in cycle M≥N+2: at M+1 ack_o=1 and new_command/new_data=0, then IDLE.
  - Timeout counter increments every EXEC cycle and clears on EXEC entry. On reaching 2^TIMEOUT_W-1 without done: next cycle err_o=1 (no ack_o), request dropped, then IDLE.
  - Done and timeout in the same cycle: done wins.
- Abort: cyc_i or stb_i low during RD_REQ/RD_WAIT/EXEC → next cycle IDLE, requests and strobes cleared, no ack_o/err_o.
- Back-to-back: stb_i still high in the IDLE cycle after ack_o is a new transfer. Maximum rate is one write per 2 cycles.
- ack_o and err_o are never high together; dat_o is 0 except in the ack cycle of a read.

Test Plan:
- Reset released, write adr=3 dat=0xA5 at N → N+1 reg_write_en=1, host_data_o=0xA5, ack_o=1; N+2 all 0.
- Read adr=20, host_data_i=0x1234 valid at N+2 (READ_LAT=1) → fifo_read_en at N+1; ack_o=1, dat_o=0x1234 at N+3.
- CMD write 0xDEAD, cmd_done_i high at N+1 and N+5 → N+1 done ignored; new_command high N+1..N+5; ack_o at N+6, new_command=0 at N+6.
- DATA write, TIMEOUT_W=3, data_done_i never → new_data high 7 cycles; err_o=1 one cycle, ack_o=0.
- EXEC abort: stb_i dropped at N+3 → N+4 new_command=0, no ack_o/err_o; reset low mid-EXEC → outputs 0 asynchronously.
- Back-to-back writes adr 19 then adr 5 → fifo_write_en at N+1, reg_write_en at N+3, each with ack_o.
